uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 171 +++++++++++++++++
 tb/tb_uart_rx.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, 8N1, mid-bit sampling, one-clock byte and frame-error strobes
//
// Purpose:
//   Receives 1 start bit, 8 data bits LSB-first, 1 stop bit, no parity from an
//   asynchronous serial line. The line is passed through a 2-flop synchronizer,
//   the start edge is qualified at its mid-point, and every following bit is
//   sampled one bit period later, which lands near its centre.
//
// Ports:
//   i_Clock         in   1  system clock, rising edge
//   i_Reset         in   1  asynchronous active-high reset
//   i_Rx_Serial     in   1  asynchronous serial line, idle high
//   o_Rx_DV         out  1  one-clock strobe, o_Rx_Byte holds a new byte
//   o_Rx_Byte       out  8  last correctly framed byte, held until the next one
//   o_Rx_Active     out  1  high while a frame is in progress (START..STOP)
//   o_Rx_Frame_Err  out  1  one-clock strobe, stop bit sampled low

`timescale 1ns/1ps

module uart_rx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_Serial,
  output logic       o_Rx_DV,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_Active,
  output logic       o_Rx_Frame_Err
);

  localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [2:0]    bit_idx;
  logic [2:0]    bit_idx_next;
  logic [7:0]    shift;
  logic [7:0]    shift_next;
  logic [7:0]    byte_next;
  logic          dv_next;
  logic          err_next;

  logic          rx_meta;
  logic          rx_s;

  // Synchronizer resets to the idle (high) level so a reset never looks
  // like a start edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_Rx_Serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state          <= IDLE;
      cnt            <= '0;
      bit_idx        <= 3'd0;
      shift          <= 8'h00;
      o_Rx_Byte      <= 8'h00;
      o_Rx_DV        <= 1'b0;
      o_Rx_Frame_Err <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      bit_idx        <= bit_idx_next;
      shift          <= shift_next;
      o_Rx_Byte      <= byte_next;
      o_Rx_DV        <= dv_next;
      o_Rx_Frame_Err <= err_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    byte_next    = o_Rx_Byte;
    dv_next      = 1'b0;
    err_next     = 1'b0;

    case (state)
      IDLE: begin
        cnt_next     = '0;
        bit_idx_next = 3'd0;
        if (!rx_s) begin
          state_next = START;
        end
      end

      // Re-check the line half a bit after the edge; a line that is high
      // again was only a glitch.
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_next     = '0;
          bit_idx_next = 3'd0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      // Sampling a full bit period after the mid-start point keeps every
      // sample near the centre of its bit.
      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      // The stop bit is judged mid-bit, leaving half a bit of margin so the
      // next start edge can follow immediately.
      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_next   = '0;
          state_next = CLEANUP;
          if (rx_s) begin
            byte_next = shift;
            dv_next   = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end

      CLEANUP: begin
        cnt_next   = '0;
        state_next = IDLE;
      end

      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
  end

  assign o_Rx_Active = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with randomized frames and a frame-level reference model

`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB        = 87;
  localparam int HALF       = (CPB - 1) / 2;
  localparam int CLK_NS     = 50;
  localparam int BIT_NS     = CPB * CLK_NS;
  localparam int LAT        = 2 + 1 + (HALF + 1) + 9 * CPB;
  localparam int ACTIVE_CYC = (HALF + 1) + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       rx_active;
  logic       rx_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] last_good = 8'h00;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_Rx_Serial    (rx),
    .o_Rx_DV        (rx_dv),
    .o_Rx_Byte      (rx_byte),
    .o_Rx_Active    (rx_active),
    .o_Rx_Frame_Err (rx_err)
  );

  always #(CLK_NS / 2) clk = ~clk;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
    int         t;
  } ev_t;

  ev_t  ev_q[$];
  int   cyc         = 0;
  int   active_cyc  = 0;
  int   long_strobe = 0;
  int   both_strobe = 0;
  logic prev_dv     = 1'b0;
  logic prev_err    = 1'b0;

  always @(negedge clk) begin
    ev_t e;
    cyc = cyc + 1;
    if (rx_active === 1'b1) active_cyc = active_cyc + 1;
    if (rx_dv === 1'b1 && rx_err === 1'b1) both_strobe = both_strobe + 1;
    if ((rx_dv === 1'b1 && prev_dv) || (rx_err === 1'b1 && prev_err)) long_strobe = long_strobe + 1;
    if (rx_dv === 1'b1 || rx_err === 1'b1) begin
      e.is_err = (rx_err === 1'b1);
      e.data   = rx_byte;
      e.t      = cyc;
      ev_q.push_back(e);
    end
    prev_dv  = (rx_dv === 1'b1);
    prev_err = (rx_err === 1'b1);
  end

  // Ideal asynchronous-timing frame: the line is driven from time delays only.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    rx = 1'b0;
    t0 = cyc;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(BIT_NS);
    end
    rx = stop;
    #(BIT_NS);
    rx = 1'b1;
  endtask

  task automatic align;
    @(posedge clk);
    #13;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (rx_dv !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b expected 0", rx_dv); end
    n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_byte: got %h expected 00", rx_byte); end
    n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", rx_active); end
    n_checks++; if (rx_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", rx_err); end
    #7;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("FAIL idle_active: got %b expected 0", rx_active); end
    n_checks++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL idle_events: got %0d expected 0", ev_q.size()); end
  endtask

  task automatic test_single_byte;
    int t0;
    int a0;
    ev_q.delete();
    align();
    a0 = active_cyc;
    send_frame(8'h3F, 1'b1, t0);
    #(BIT_NS);
    n_checks++; if (ev_q.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d events expected 1", ev_q.size()); end
    if (ev_q.size() >= 1) begin
      n_checks++; if (ev_q[0].is_err !== 1'b0) begin n_fail++; $display("FAIL single_kind: got err expected dv"); end
      n_checks++; if (ev_q[0].data !== 8'h3F) begin n_fail++; $display("FAIL single_byte: got %h expected 3f", ev_q[0].data); end
      n_checks++;
      if ((ev_q[0].t - t0 - LAT) < -2 || (ev_q[0].t - t0 - LAT) > 2) begin
        n_fail++; $display("FAIL single_latency: got %0d expected %0d +-2", ev_q[0].t - t0, LAT);
      end
    end
    n_checks++;
    if ((active_cyc - a0) < ACTIVE_CYC - 2 || (active_cyc - a0) > ACTIVE_CYC + 2) begin
      n_fail++; $display("FAIL single_active_len: got %0d expected %0d +-2", active_cyc - a0, ACTIVE_CYC);
    end
    n_checks++; if (rx_byte !== 8'h3F) begin n_fail++; $display("FAIL single_hold: got %h expected 3f", rx_byte); end
    last_good = 8'h3F;
  endtask

  // Clock-synchronous transmitter model standing in for the transmit side.
  task automatic test_loopback;
    logic [9:0] frame;
    int         t_start;
    int         t_done;
    ev_q.delete();
    frame = {1'b1, 8'b01110101, 1'b0};
    @(posedge clk);
    #1;
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    t_done = cyc;
    rx = 1'b1;
    #(BIT_NS);
    n_checks++; if (ev_q.size() != 1) begin n_fail++; $display("FAIL loop_count: got %0d events expected 1", ev_q.size()); end
    if (ev_q.size() >= 1) begin
      n_checks++; if (ev_q[0].is_err !== 1'b0 || ev_q[0].data !== 8'h75) begin
        n_fail++; $display("FAIL loop_byte: got err=%b byte=%h expected dv byte 75", ev_q[0].is_err, ev_q[0].data);
      end
      n_checks++;
      if ((ev_q[0].t - t_start - LAT) < -2 || (ev_q[0].t - t_start - LAT) > 2 || ev_q[0].t > t_done) begin
        n_fail++; $display("FAIL loop_latency: got %0d expected %0d +-2 before done at %0d", ev_q[0].t - t_start, LAT, t_done - t_start);
      end
    end
    last_good = 8'h75;
  endtask

  task automatic test_back_to_back;
    int t0;
    int t1;
    ev_q.delete();
    align();
    send_frame(8'h55, 1'b1, t0);
    send_frame(8'hA3, 1'b1, t1);
    #(BIT_NS);
    n_checks++; if (ev_q.size() != 2) begin n_fail++; $display("FAIL b2b_count: got %0d events expected 2", ev_q.size()); end
    if (ev_q.size() >= 2) begin
      n_checks++; if (ev_q[0].is_err !== 1'b0 || ev_q[0].data !== 8'h55) begin
        n_fail++; $display("FAIL b2b_first: got err=%b byte=%h expected dv 55", ev_q[0].is_err, ev_q[0].data);
      end
      n_checks++; if (ev_q[1].is_err !== 1'b0 || ev_q[1].data !== 8'hA3) begin
        n_fail++; $display("FAIL b2b_second: got err=%b byte=%h expected dv a3", ev_q[1].is_err, ev_q[1].data);
      end
      n_checks++;
      if ((ev_q[1].t - ev_q[0].t) < 10 * CPB - 2 || (ev_q[1].t - ev_q[0].t) > 10 * CPB + 2) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d expected %0d +-2", ev_q[1].t - ev_q[0].t, 10 * CPB);
      end
    end
    last_good = 8'hA3;
  endtask

  task automatic test_glitch;
    int waited;
    ev_q.delete();
    align();
    rx = 1'b0;
    #(20 * CLK_NS);
    rx = 1'b1;
    waited = 0;
    while (rx_active === 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("FAIL glitch_active: got %b after %0d clocks expected 0", rx_active, waited); end
    #(2 * BIT_NS);
    n_checks++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL glitch_events: got %0d expected 0", ev_q.size()); end
  endtask

  task automatic test_frame_err;
    int t0;
    ev_q.delete();
    align();
    send_frame(8'hC4, 1'b0, t0);
    #(2 * BIT_NS);
    n_checks++; if (ev_q.size() != 1) begin n_fail++; $display("FAIL ferr_count: got %0d events expected 1", ev_q.size()); end
    if (ev_q.size() >= 1) begin
      n_checks++; if (ev_q[0].is_err !== 1'b1) begin n_fail++; $display("FAIL ferr_kind: got dv expected err"); end
      n_checks++;
      if ((ev_q[0].t - t0 - LAT) < -2 || (ev_q[0].t - t0 - LAT) > 2) begin
        n_fail++; $display("FAIL ferr_latency: got %0d expected %0d +-2", ev_q[0].t - t0, LAT);
      end
    end
    n_checks++; if (rx_byte !== last_good) begin n_fail++; $display("FAIL ferr_hold: got %h expected %h", rx_byte, last_good); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    int         t0;
    d = 8'h96;
    ev_q.delete();
    align();
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      #(BIT_NS);
    end
    rx = d[4];
    #(BIT_NS / 2);
    #7;
    n_checks++; if (rx_active !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_active: got %b expected 1", rx_active); end
    rst = 1'b1;
    #1;
    n_checks++; if (rx_active !== 1'b0) begin n_fail++; $display("FAIL midrst_active: got %b expected 0", rx_active); end
    n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL midrst_byte: got %h expected 00", rx_byte); end
    n_checks++; if (rx_dv !== 1'b0 || rx_err !== 1'b0) begin n_fail++; $display("FAIL midrst_strobes: got dv=%b err=%b expected 0 0", rx_dv, rx_err); end
    rx = 1'b1;
    #(3 * CLK_NS);
    rst = 1'b0;
    last_good = 8'h00;
    #(BIT_NS);
    n_checks++; if (ev_q.size() != 0) begin n_fail++; $display("FAIL midrst_events: got %0d expected 0", ev_q.size()); end
    ev_q.delete();
    align();
    send_frame(8'h5A, 1'b1, t0);
    #(BIT_NS);
    n_checks++;
    if (ev_q.size() != 1 || ev_q[0].is_err !== 1'b0 || ev_q[0].data !== 8'h5A) begin
      n_fail++; $display("FAIL midrst_after: got %0d events, first byte %h expected one dv 5a", ev_q.size(), (ev_q.size() > 0) ? ev_q[0].data : 8'hxx);
    end
    last_good = 8'h5A;
  endtask

  // Reference model: a frame with a high stop bit yields one DV carrying the
  // sent byte; a low stop bit yields one error with the last good byte held.
  task automatic test_random;
    logic [7:0] d;
    logic       stop;
    int         t0;
    align();
    for (int n = 0; n < 8; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      ev_q.delete();
      send_frame(d, stop, t0);
      #(BIT_NS * $urandom_range(1, 3));
      n_checks++; if (ev_q.size() != 1) begin n_fail++; $display("FAIL rand_count[%0d]: got %0d events expected 1", n, ev_q.size()); end
      if (ev_q.size() >= 1) begin
        n_checks++;
        if (ev_q[0].is_err !== !stop || ev_q[0].data !== (stop ? d : last_good)) begin
          n_fail++; $display("FAIL rand_event[%0d]: got err=%b byte=%h expected err=%b byte=%h", n, ev_q[0].is_err, ev_q[0].data, !stop, stop ? d : last_good);
        end
      end
      if (stop) last_good = d;
    end
  endtask

  task automatic test_strobe_rules;
    n_checks++; if (long_strobe != 0) begin n_fail++; $display("FAIL strobe_width: got %0d long strobes expected 0", long_strobe); end
    n_checks++; if (both_strobe != 0) begin n_fail++; $display("FAIL strobe_exclusive: got %0d overlaps expected 0", both_strobe); end
  endtask

  initial begin
    #(200000 * CLK_NS);
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_byte();
    test_loopback();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid_frame();
    test_random();
    test_strobe_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
